// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative shift-and-add-3 binary-to-BCD converter with start/done handshake.
// Define BIN2BCD_SEG_EN to add a registered active-low seven-segment output (hex).
module bin2bcd_seq #(
  parameter int W = 5,
  parameter int DIGITS = 2
) (
  input  logic                  CLOCK_50,
  input  logic                  RESETN,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
`ifdef BIN2BCD_SEG_EN
  ,
  output logic [7*DIGITS-1:0]   hex
`endif
);
  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * DIGITS;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [W-1:0] sr_q, sr_d, sr_sh;
  logic [BW-1:0] sc_q, sc_d, adj, sc_sh;
  logic [CW-1:0] cnt_q, cnt_d;
  logic of_q, of_d, carry, fin;
  assign busy = state_q == SHIFT;
  always_comb begin
    for (int k = 0; k < DIGITS; k++)
      adj[4*k +: 4] = sc_q[4*k +: 4] >= 4'd5 ? sc_q[4*k +: 4] + 4'd3 : sc_q[4*k +: 4];
    {carry, sc_sh, sr_sh} = {adj, sr_q, 1'b0};
    state_d = state_q;
    sr_d = sr_q;
    sc_d = sc_q;
    of_d = of_q;
    cnt_d = cnt_q;
    fin = 1'b0;
    if (state_q == IDLE && start) begin
      sr_d = bin;
      sc_d = '0;
      of_d = 1'b0;
      cnt_d = CW'(W);
      state_d = SHIFT;
    end else if (state_q == SHIFT) begin
      sr_d = sr_sh;
      sc_d = sc_sh;
      of_d = of_q | carry;
      cnt_d = cnt_q - 1'b1;
      fin = cnt_q == CW'(1);
      state_d = fin ? IDLE : SHIFT;
    end
  end
  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
      sr_q <= '0;
      sc_q <= '0;
      of_q <= 1'b0;
      cnt_q <= '0;
      done <= 1'b0;
      bcd <= '0;
      ovf <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      sc_q <= sc_d;
      of_q <= of_d;
      cnt_q <= cnt_d;
      done <= fin;
      if (fin) begin
        bcd <= sc_d;
        ovf <= of_d;
      end
    end
  end
`ifdef BIN2BCD_SEG_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'b0111111;
    endcase
  endfunction
  logic [7*DIGITS-1:0] hex_d;
  always_comb begin
    for (int k = 0; k < DIGITS; k++)
      hex_d[7*k +: 7] = of_d ? 7'b0111111 : seg7(sc_d[4*k +: 4]);
  end
  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) hex <= {DIGITS{7'b1000000}};
    else if (fin) hex <= hex_d;
  end
`endif
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: vector table, hand sequences and random checks of bin2bcd_seq (W=5 and W=8).
module tb_bin2bcd_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start8 = 1'b0;
  logic [4:0] bin = '0;
  logic [7:0] bin8 = '0;
  logic busy, done, ovf, busy8, done8, ovf8;
  logic [7:0] bcd, bcd8;
`ifdef BIN2BCD_SEG_EN
  logic [13:0] hex, hex8;
`endif
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.W(5), .DIGITS(2)) dut (
    .CLOCK_50(clk), .RESETN(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
`ifdef BIN2BCD_SEG_EN
    , .hex(hex)
`endif
  );

  bin2bcd_seq #(.W(8), .DIGITS(2)) dut8 (
    .CLOCK_50(clk), .RESETN(rst_n), .start(start8), .bin(bin8),
    .busy(busy8), .done(done8), .bcd(bcd8), .ovf(ovf8)
`ifdef BIN2BCD_SEG_EN
    , .hex(hex8)
`endif
  );

  typedef struct {int b; logic [7:0] e; logic o;} vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // expected {ovf, bcd} from plain decimal arithmetic
  function automatic logic [8:0] model(input int v);
    int m = v % 100;
    return {v > 99 ? 1'b1 : 1'b0, 4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic go(input int v);
    @(negedge clk);
    bin = 5'(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait5(output int n, output bit stable, output int bc);
    logic [7:0] b0 = bcd;
    n = 0;
    stable = 1'b1;
    bc = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
      if (!done && bcd !== b0) stable = 1'b0;
    end
  endtask

  task automatic run8(input int v, input string nm);
    int n = 0;
    logic [8:0] m = model(v);
    @(negedge clk);
    bin8 = 8'(v);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s lat8 %0d", nm, v), n, 8);
    chk($sformatf("%s bcd8 %0d", nm, v), bcd8, m[7:0]);
    chk($sformatf("%s ovf8 %0d", nm, v), ovf8, m[8]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[8];
    vec_t t8[5];
    int n, bc, dc;
    bit st;
    logic [7:0] got;
    logic [8:0] m;
    tbl = '{'{0, 8'h00, 1'b0}, '{9, 8'h09, 1'b0}, '{10, 8'h10, 1'b0}, '{31, 8'h31, 1'b0},
            '{19, 8'h19, 1'b0}, '{25, 8'h25, 1'b0}, '{27, 8'h27, 1'b0}, '{15, 8'h15, 1'b0}};
    t8 = '{'{200, 8'h00, 1'b1}, '{99, 8'h99, 1'b0}, '{255, 8'h55, 1'b1},
           '{100, 8'h00, 1'b1}, '{0, 8'h00, 1'b0}};
    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst bcd", bcd, 0);
    chk("rst ovf", ovf, 0);
`ifdef BIN2BCD_SEG_EN
    chk("rst hex", hex, {2{7'b1000000}});
`endif
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      go(tbl[i].b);
      wait5(n, st, bc);
      chk($sformatf("tbl lat %0d", tbl[i].b), n, 5);
      chk($sformatf("tbl busy %0d", tbl[i].b), bc, 5);
      chk($sformatf("tbl stable %0d", tbl[i].b), st, 1);
      chk($sformatf("tbl bcd %0d", tbl[i].b), bcd, tbl[i].e);
      chk($sformatf("tbl ovf %0d", tbl[i].b), ovf, tbl[i].o);
`ifdef BIN2BCD_SEG_EN
      if (tbl[i].b == 27) chk("hex 27", hex, {7'b0100100, 7'b1111000});
`endif
      @(negedge clk);
      chk($sformatf("tbl done pulse %0d", tbl[i].b), done, 0);
    end
    for (int i = 0; i < 20; i++) begin
      int v = $urandom_range(0, 31);
      m = model(v);
      go(v);
      wait5(n, st, bc);
      chk($sformatf("rnd lat %0d", v), n, 5);
      chk($sformatf("rnd bcd %0d", v), bcd, m[7:0]);
      chk($sformatf("rnd ovf %0d", v), ovf, m[8]);
    end
    // back-to-back: start held in the done cycle
    go(0);
    wait5(n, st, bc);
    chk("b2b first bcd", bcd, 8'h00);
    bin = 5'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b accepted busy", busy, 1);
    wait5(n, st, bc);
    chk("b2b lat", n, 5);
    chk("b2b stable", st, 1);
    chk("b2b bcd", bcd, 8'h10);
    // start while busy is ignored
    go(19);
    repeat (2) @(negedge clk);
    bin = 5'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin = 5'd0;
    dc = 0;
    got = '0;
    repeat (12) begin
      @(negedge clk);
      if (done) begin
        dc++;
        got = bcd;
      end
    end
    chk("ignore done count", dc, 1);
    chk("ignore bcd", got, 8'h19);
    // asynchronous reset mid-conversion
    go(25);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst bcd", bcd, 0);
    chk("midrst ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dc++;
    end
    chk("midrst no done", dc, 0);
    go(25);
    wait5(n, st, bc);
    chk("post rst lat", n, 5);
    chk("post rst bcd", bcd, 8'h25);
    // wider input with overflow
    foreach (t8[i]) begin
      run8(t8[i].b, "tbl8");
      chk($sformatf("tbl8 exp bcd %0d", t8[i].b), bcd8, t8[i].e);
      chk($sformatf("tbl8 exp ovf %0d", t8[i].b), ovf8, t8[i].o);
`ifdef BIN2BCD_SEG_EN
      if (t8[i].b == 200) chk("hex8 dash", hex8, {2{7'b0111111}});
`endif
    end
    for (int i = 0; i < 10; i++) run8($urandom_range(0, 255), "rnd8");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
